// File: rtl/instruction_dispatcher.sv
// instruction_dispatcher
//   Queues 148-bit host instructions in a FIFO and issues them one at a time
//   to the control unit. Each instruction is held on `instruction` for a
//   per-opcode number of cycles. Back-to-back issue happens with no gap
//   cycle. Illegal opcodes are issued as a one-cycle all-zeros word and set
//   a sticky error flag.
//
// Ports
//   clk, reset_n   : rising-edge clock, asynchronous active-low reset
//   inst_in        : host instruction {opcode[3:0], ADDRA[7:0], ADDRB[7:0], OPERAND[127:0]}
//   inst_valid     : host offers inst_in; it is accepted when inst_ready is high
//   inst_ready     : queue has room
//   stall          : freezes the issue side (pushes still accepted)
//   clear_error    : clears op_error (a simultaneous new error wins)
//   instruction    : registered instruction presented to the control unit
//   issue_start    : one-cycle pulse on the first cycle of each issued instruction
//   fifo_count     : number of queued entries
//   busy           : instruction in flight or queue non-empty
//   op_error       : sticky illegal-opcode flag
module instruction_dispatcher #(
  parameter int unsigned FIFO_DEPTH         = 16,
  parameter int unsigned IDLE_CYCLE         = 1,
  parameter int unsigned WRITE_DATA_CYCLE   = 1,
  parameter int unsigned WRITE_WEIGHT_CYCLE = 1,
  parameter int unsigned LOAD_DATA_CYCLE    = 2,
  parameter int unsigned LOAD_WEIGHT_CYCLE  = 2,
  parameter int unsigned MAT_MUL_CYCLE      = 34
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [147:0]                  inst_in,
  input  logic                          inst_valid,
  output logic                          inst_ready,
  input  logic                          stall,
  input  logic                          clear_error,
  output logic [147:0]                  instruction,
  output logic                          issue_start,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          op_error
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  localparam logic [3:0] OP_IDLE         = 4'd0;
  localparam logic [3:0] OP_WRITE_DATA   = 4'd1;
  localparam logic [3:0] OP_WRITE_WEIGHT = 4'd2;
  localparam logic [3:0] OP_LOAD_DATA    = 4'd3;
  localparam logic [3:0] OP_LOAD_WEIGHT  = 4'd4;
  localparam logic [3:0] OP_MAT_MUL      = 4'd5;
  localparam logic [3:0] OP_MAT_MUL_ACC  = 4'd6;

  function automatic logic [7:0] hold_cycles(input logic [3:0] op);
    logic [7:0] c;
    case (op)
      OP_IDLE:         c = 8'(IDLE_CYCLE);
      OP_WRITE_DATA:   c = 8'(WRITE_DATA_CYCLE);
      OP_WRITE_WEIGHT: c = 8'(WRITE_WEIGHT_CYCLE);
      OP_LOAD_DATA:    c = 8'(LOAD_DATA_CYCLE);
      OP_LOAD_WEIGHT:  c = 8'(LOAD_WEIGHT_CYCLE);
      OP_MAT_MUL,
      OP_MAT_MUL_ACC:  c = 8'(MAT_MUL_CYCLE);
      default:         c = 8'd1;
    endcase
    return c;
  endfunction

  logic [147:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [0:0]       state_q, state_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [147:0]     instruction_q, instruction_d;
  logic             issue_start_q, issue_start_d;
  logic             op_error_q, op_error_d;

  logic             push, pop, can_issue, head_legal;
  logic [147:0]     head;
  logic [3:0]       head_op;

  assign inst_ready  = (count_q < DEPTH_C);
  assign busy        = (state_q == S_HOLD) || (count_q != '0);
  assign instruction = instruction_q;
  assign issue_start = issue_start_q;
  assign op_error    = op_error_q;
  assign fifo_count  = count_q;

  always_comb begin
    push       = inst_valid && inst_ready;
    // The issue side may take a new entry when idle or on the last hold cycle,
    // which is what makes back-to-back issue gapless.
    can_issue  = !stall && ((state_q == S_IDLE) || (hold_cnt_q == '0));
    pop        = can_issue && (count_q != '0);
    head       = mem_q[rd_ptr_q];
    head_op    = head[147:144];
    head_legal = (head_op <= OP_MAT_MUL_ACC);

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    instruction_d = instruction_q;
    issue_start_d = 1'b0;
    op_error_d    = clear_error ? 1'b0 : op_error_q;

    if (pop) begin
      state_d       = S_HOLD;
      issue_start_d = 1'b1;
      if (head_legal) begin
        instruction_d = head;
        hold_cnt_d    = hold_cycles(head_op) - 8'd1;
      end else begin
        // Illegal opcode: one all-zeros cycle; the set overrides clear_error.
        instruction_d = '0;
        hold_cnt_d    = '0;
        op_error_d    = 1'b1;
      end
    end else if (can_issue && (state_q == S_HOLD)) begin
      state_d       = S_IDLE;
      instruction_d = '0;
    end else if (!stall && (state_q == S_HOLD)) begin
      hold_cnt_d = hold_cnt_q - 8'd1;
    end
  end

  // Queue storage carries no reset; only pointers and count define contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= inst_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= S_IDLE;
      hold_cnt_q    <= '0;
      instruction_q <= '0;
      issue_start_q <= 1'b0;
      op_error_q    <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      instruction_q <= instruction_d;
      issue_start_q <= issue_start_d;
      op_error_q    <= op_error_d;
    end
  end

endmodule

// File: tb/tb_instruction_dispatcher.sv
// tb_instruction_dispatcher
//   Directed bench for instruction_dispatcher. Expected per-cycle outputs
//   (instruction word and issue_start) are queued when stimulus is driven and
//   compared cycle by cycle once the DUT starts issuing.
module tb_instruction_dispatcher;

  logic         clk;
  logic         reset_n;
  logic [147:0] inst_in;
  logic         inst_valid;
  logic         inst_ready;
  logic         stall;
  logic         clear_error;
  logic [147:0] instruction;
  logic         issue_start;
  logic [4:0]   fifo_count;
  logic         busy;
  logic         op_error;

  instruction_dispatcher #(
    .FIFO_DEPTH         (16),
    .IDLE_CYCLE         (1),
    .WRITE_DATA_CYCLE   (1),
    .WRITE_WEIGHT_CYCLE (1),
    .LOAD_DATA_CYCLE    (2),
    .LOAD_WEIGHT_CYCLE  (2),
    .MAT_MUL_CYCLE      (34)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .inst_in     (inst_in),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .stall       (stall),
    .clear_error (clear_error),
    .instruction (instruction),
    .issue_start (issue_start),
    .fifo_count  (fifo_count),
    .busy        (busy),
    .op_error    (op_error)
  );

  typedef struct {
    logic [147:0] instr;
    logic         issue;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [147:0] obs, input logic [147:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [147:0] mk(input logic [3:0] op, input logic [7:0] a,
                                      input logic [7:0] b);
    logic [127:0] operand;
    operand = {$urandom, $urandom, $urandom, $urandom};
    return {op, a, b, operand};
  endfunction

  // Queue the per-cycle expectation of one issued instruction.
  task automatic sb_add(input logic [147:0] word, input int cycles);
    exp_t e;
    for (int i = 0; i < cycles; i++) begin
      e.instr = word;
      e.issue = (i == 0);
      sb.push_back(e);
    end
  endtask

  task automatic push(input logic [147:0] word);
    inst_in    = word;
    inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
  endtask

  // Waits (bounded) for the first issue_start, then compares every queued
  // cycle, optionally pulsing stall, and finally checks the return to idle.
  task automatic run_stream(input string tag, input int budget,
                            input int stall_at, input int stall_len);
    int   waited;
    int   idx;
    exp_t e;
    waited = 0;
    while (issue_start !== 1'b1 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    chk_n({tag, "_first_issue"}, 32'(issue_start), 32'd1);
    if (issue_start === 1'b1) begin
      idx = 0;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        chk({tag, "_instr"}, instruction, e.instr);
        chk_n({tag, "_issue"}, 32'(issue_start), 32'(e.issue));
        if (idx == stall_at) stall = 1'b1;
        if (idx == stall_at + stall_len) stall = 1'b0;
        idx++;
        if (sb.size() > 0) @(negedge clk);
      end
      @(negedge clk);
      chk({tag, "_idle_instr"}, instruction, 148'd0);
      chk_n({tag, "_idle_busy"}, 32'(busy), 32'd0);
      chk_n({tag, "_idle_issue"}, 32'(issue_start), 32'd0);
    end else begin
      sb.delete();
    end
  endtask

  initial begin
    logic [147:0] w0, w1, w2;
    reset_n     = 1'b0;
    inst_in     = '0;
    inst_valid  = 1'b0;
    stall       = 1'b0;
    clear_error = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_instr", instruction, 148'd0);
    chk_n("rst_issue", 32'(issue_start), 32'd0);
    chk_n("rst_count", 32'(fifo_count), 32'd0);
    chk_n("rst_busy", 32'(busy), 32'd0);
    chk_n("rst_err", 32'(op_error), 32'd0);
    chk_n("rst_ready", 32'(inst_ready), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // Single LOAD_DATA: one-edge latency, 2 cycles, then idle
    w0 = mk(4'd3, 8'd0, 8'd3);
    push(w0);
    sb_add(w0, 2);
    chk_n("single_lat_issue", 32'(issue_start), 32'd0);
    chk("single_lat_instr", instruction, 148'd0);
    chk_n("single_lat_count", 32'(fifo_count), 32'd1);
    chk_n("single_lat_busy", 32'(busy), 32'd1);
    run_stream("single", 1, -1, 0);

    // Back-to-back MAT_MUL then LOAD_DATA
    w0 = mk(4'd5, 8'd0, 8'd7);
    w1 = mk(4'd3, 8'd9, 8'd0);
    sb_add(w0, 34);
    sb_add(w1, 2);
    inst_in = w0; inst_valid = 1'b1;
    @(negedge clk);
    inst_in = w1;
    @(negedge clk);
    inst_valid = 1'b0;
    run_stream("b2b", 2, -1, 0);

    // Full queue under stall: 17 offered, 16 accepted, issued in order
    stall = 1'b1;
    for (int i = 0; i < 17; i++) begin
      w0 = mk(4'd1, 8'(i), 8'd0);
      inst_in = w0; inst_valid = 1'b1;
      chk_n("full_ready", 32'(inst_ready), (i < 16) ? 32'd1 : 32'd0);
      if (i < 16) sb_add(w0, 1);
      @(negedge clk);
    end
    inst_valid = 1'b0;
    chk_n("full_ready_end", 32'(inst_ready), 32'd0);
    chk_n("full_count", 32'(fifo_count), 32'd16);
    chk_n("full_stalled_issue", 32'(issue_start), 32'd0);
    chk("full_stalled_instr", instruction, 148'd0);
    stall = 1'b0;
    run_stream("full", 2, -1, 0);

    // Stall for 5 cycles mid MAT_MUL: visible 39 cycles, single pulse
    w0 = mk(4'd5, 8'd4, 8'd2);
    push(w0);
    sb_add(w0, 39);
    run_stream("stall", 2, 10, 5);

    // Illegal opcode 9
    push(mk(4'd9, 8'd1, 8'd1));
    sb_add(148'd0, 1);
    run_stream("illegal", 2, -1, 0);
    chk_n("illegal_err", 32'(op_error), 32'd1);

    // Second illegal opcode popped in the same cycle as clear_error
    w2 = mk(4'd12, 8'd2, 8'd2);
    inst_in = w2; inst_valid = 1'b1;
    @(negedge clk);
    inst_valid  = 1'b0;
    clear_error = 1'b1;
    @(negedge clk);
    clear_error = 1'b0;
    chk_n("set_wins_issue", 32'(issue_start), 32'd1);
    chk("set_wins_instr", instruction, 148'd0);
    chk_n("set_wins_err", 32'(op_error), 32'd1);
    @(negedge clk);
    chk_n("set_wins_err_hold", 32'(op_error), 32'd1);
    chk_n("set_wins_busy", 32'(busy), 32'd0);
    clear_error = 1'b1;
    @(negedge clk);
    clear_error = 1'b0;
    chk_n("clear_err", 32'(op_error), 32'd0);

    // Reset during MAT_MUL with 3 entries queued
    w0 = mk(4'd5, 8'd0, 8'd0);
    push(w0);
    inst_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inst_in = mk(4'd1, 8'(8'd100 + 8'(i)), 8'd0);
      @(negedge clk);
    end
    inst_valid = 1'b0;
    chk_n("rmid_count", 32'(fifo_count), 32'd3);
    chk("rmid_instr", instruction, w0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rmid_rst_instr", instruction, 148'd0);
    chk_n("rmid_rst_count", 32'(fifo_count), 32'd0);
    chk_n("rmid_rst_busy", 32'(busy), 32'd0);
    chk_n("rmid_rst_ready", 32'(inst_ready), 32'd1);
    chk_n("rmid_rst_issue", 32'(issue_start), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rmid_after_instr", instruction, 148'd0);
      chk_n("rmid_after_issue", 32'(issue_start), 32'd0);
    end
    chk_n("rmid_after_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_dispatcher.md
INSTRUCTION_DISPATCHER -- requirements
Module: instruction_dispatcher

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- FIFO_DEPTH, 16, instruction queue entries (power of 2).
- IDLE_CYCLE, 1, hold cycles for IDLE.
- WRITE_DATA_CYCLE, 1, hold cycles for WRITE_DATA.
- WRITE_WEIGHT_CYCLE, 1, hold cycles for WRITE_WEIGHT.
- LOAD_DATA_CYCLE, 2, hold cycles for LOAD_DATA.
- LOAD_WEIGHT_CYCLE, 2, hold cycles for LOAD_WEIGHT.
- MAT_MUL_CYCLE, 34, hold cycles for MAT_MUL and MAT_MUL_ACC.
- All hold-cycle parameters SHALL be in the range 1..255.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- inst_in, in, 148, host instruction.
- inst_valid, in, 1, host offers inst_in.
- inst_ready, out, 1, queue can accept.
- stall, in, 1, freeze the issue side.
- clear_error, in, 1, clears op_error.
- instruction, out, 148, registered instruction to CONTROL_UNIT.
- issue_start, out, 1, pulse on the first cycle of each issued instruction.
- fifo_count, out, log2(FIFO_DEPTH)+1, queued entry count.
- busy, out, 1, instruction in flight or queue non-empty.
- op_error, out, 1, sticky illegal-opcode flag.
REQ-003 Instruction layout SHALL be:
- [147:144] opcode.
- [143:136] ADDRA.
- [135:128] ADDRB.
- [127:0] OPERAND.
REQ-004 Opcodes SHALL be:
- IDLE=0, WRITE_DATA=1, WRITE_WEIGHT=2, LOAD_DATA=3, LOAD_WEIGHT=4, MAT_MUL=5, MAT_MUL_ACC=6.
- 7..15 are illegal.

Function
REQ-005 Push SHALL occur when inst_valid && inst_ready; inst_ready SHALL be (fifo_count < FIFO_DEPTH), combinational from registered count.
REQ-006 Queue SHALL be FIFO ordered, with wrap-around read/write pointers.
REQ-007 A simultaneous push and pop SHALL leave fifo_count unchanged; full blocks push via inst_ready; pop only when non-empty.
REQ-008 FSM SHALL have states S_IDLE and S_HOLD, with an 8-bit down-counter hold_cnt.
REQ-009 In S_IDLE, with fifo_count>0 and !stall, the block SHALL at the edge:
- pop the head into instruction;
- load hold_cnt=cycles(opcode)-1;
- set issue_start=1 for the following cycle;
- go to S_HOLD.
REQ-010 In S_IDLE with an empty queue, instruction SHALL be all zeros (IDLE).
REQ-011 In S_HOLD with !stall and hold_cnt>0, hold_cnt SHALL decrement and instruction SHALL stay constant.
REQ-012 In S_HOLD with !stall and hold_cnt==0:
- if the queue is non-empty, the block SHALL pop the next entry back-to-back (no gap cycle), reload hold_cnt and pulse issue_start;
- otherwise it SHALL load all-zeros and return to S_IDLE.
REQ-013 Each instruction SHALL be presented for exactly cycles(opcode) non-stalled cycles.
REQ-014 stall=1 SHALL freeze state, hold_cnt, instruction and the pop side; issue_start SHALL be 0 while stalled; pushes SHALL continue.
REQ-015 Latency: an instruction accepted at edge E into an empty queue with the FSM in S_IDLE and stall=0 SHALL appear on instruction after edge E+1.
REQ-016 An illegal opcode SHALL be popped normally, issued as all-zeros for 1 cycle, and set op_error.
REQ-017 clear_error SHALL clear op_error; a set SHALL win over a simultaneous clear.
REQ-018 busy SHALL be (state==S_HOLD) || (fifo_count!=0).
REQ-019 issue_start, instruction, op_error and the FSM state SHALL be registered outputs.

Reset
REQ-020 reset_n low SHALL asynchronously force:
- state S_IDLE;
- hold_cnt 0;
- pointers 0 and fifo_count 0;
- instruction all zeros;
- issue_start 0;
- op_error 0.
REQ-021 Reset mid-operation SHALL discard every queued and in-flight instruction; inst_ready SHALL read 1 during reset.
REQ-022 Queue storage SHALL need no reset.

Verification
REQ-023 Single instruction: push LOAD_DATA (ADDRB=3) while idle -> after edge E+1, instruction=LOAD_DATA for exactly 2 cycles, issue_start high for the first cycle only, then all zeros and busy=0.
REQ-024 Back-to-back: push MAT_MUL(ADDRA=0), LOAD_DATA(ADDRB=0) -> MAT_MUL held 34 cycles, LOAD_DATA follows with no gap, held 2 cycles, 2 issue_start pulses in total.
REQ-025 Full queue: push 17 WRITE_DATA with stall=1 -> 16 accepted, inst_ready=0, fifo_count=16; release stall -> 16 issued in order, ADDRA 0..15.
REQ-026 Stall mid-hold: stall=1 for 5 cycles during MAT_MUL -> MAT_MUL visible for 39 cycles total, no extra issue_start.
REQ-027 Illegal opcode 9 -> one all-zeros cycle and op_error=1; clear_error together with a second illegal opcode -> op_error stays 1; clear_error alone -> op_error=0.
REQ-028 Reset during MAT_MUL with 3 entries queued -> instruction=0, fifo_count=0 and busy=0 immediately; no queued entry is issued afterwards.
